ysyx_24100006_lsu: RTL and testbench

YSYX_24100006_LSU -- requirements
Module: ysyx_24100006_lsu

---
 rtl/ysyx_24100006_lsu.sv | 255 +++++++++++++++++++++++++
 tb/tb_ysyx_24100006_lsu.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_lsu.sv
// ysyx_24100006_lsu -- load/store unit between EXU and WBU with AXI-lite style
// read (AR/R) and write (AW/W/B) channels toward memory.
//
// Ports:
//   clk, reset            sole rising-edge clock; asynchronous active-low reset
//   in_valid / in_ready   request handshake from EXU (ready only in IDLE)
//   alu_result            access address
//   rs2_data              store data (unshifted)
//   Mem_Read / Mem_Write  load / store request (store has priority)
//   Mem_WMask             store size: 8'h01 byte, 8'h03 half, 8'h0F word
//   Mem_RMask             load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//   out_valid / out_ready result handshake toward WBU
//   alu_result_W          captured address
//   mem_rdata             extended load data (0 for stores/faults/non-memory)
//   access_fault          misalignment or nonzero bus response
//   ar*/r*                read address / read data channels
//   aw*/w*/b*             write address / write data / write response channels
module ysyx_24100006_lsu (
  input  logic        clk,
  input  logic        reset,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [7:0]  Mem_WMask,
  input  logic [2:0]  Mem_RMask,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_result_W,
  output logic [31:0] mem_rdata,
  output logic        access_fault,

  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,

  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [2:0]  r_rmask;
  logic        r_aw_pend;
  logic        r_w_pend;
  logic [31:0] r_mem_rdata;
  logic        r_fault;

  logic        w_accept;
  logic        w_mis_st;
  logic        w_mis_ld;
  logic        w_aw_done;
  logic        w_w_done;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_ext;
  logic [31:0] w_wdata_sh;
  logic        w_unused;

  // Upper store-mask bits carry no meaning for a 32-bit bus.
  assign w_unused = ^Mem_WMask[7:4];

  assign w_accept = in_valid && in_ready;

  // Alignment is judged from the live request inputs so a faulting access
  // can skip the bus entirely and land in DONE one cycle after accept.
  assign w_mis_st = ((Mem_WMask[3:0] == 4'hF) && (alu_result[1:0] != 2'b00)) ||
                    ((Mem_WMask[3:0] == 4'h3) && alu_result[0]);
  assign w_mis_ld = ((Mem_RMask[1:0] == 2'b10) && (alu_result[1:0] != 2'b00)) ||
                    ((Mem_RMask[1:0] == 2'b01) && alu_result[0]);

  // A write channel is finished if it already handshook or does so now.
  assign w_aw_done = !r_aw_pend || awready;
  assign w_w_done  = !r_w_pend  || wready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (Mem_Write) begin
            w_next = w_mis_st ? DONE : WR_REQ;
          end else if (Mem_Read) begin
            w_next = w_mis_ld ? DONE : RD_ADDR;
          end else begin
            w_next = DONE;
          end
        end
      end
      RD_ADDR: if (arready)                 w_next = RD_DATA;
      RD_DATA: if (rvalid)                  w_next = DONE;
      WR_REQ:  if (w_aw_done && w_w_done)   w_next = WR_RESP;
      WR_RESP: if (bvalid)                  w_next = DONE;
      DONE:    if (out_ready)               w_next = IDLE;
      default:                              w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load data extraction
  // ---------------------------------------------------------------------------
  always_comb begin
    w_byte = rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      2'd3: w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = r_addr[1] ? rdata[31:16] : rdata[15:0];

    w_load_ext = rdata;
    case (r_rmask)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_ext = {24'h0, w_byte};
      3'b101:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store data lane placement
  // ---------------------------------------------------------------------------
  always_comb begin
    w_wdata_sh = r_wdata;
    case (r_addr[1:0])
      2'd0: w_wdata_sh = r_wdata;
      2'd1: w_wdata_sh = {r_wdata[23:0], 8'h00};
      2'd2: w_wdata_sh = {r_wdata[15:0], 16'h0000};
      2'd3: w_wdata_sh = {r_wdata[7:0], 24'h000000};
      default: w_wdata_sh = r_wdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture, write-channel bookkeeping and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_rmask     <= '0;
      r_aw_pend   <= 1'b0;
      r_w_pend    <= 1'b0;
      r_mem_rdata <= '0;
      r_fault     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr      <= alu_result;
            r_wdata     <= rs2_data;
            r_wmask     <= Mem_WMask[3:0];
            r_rmask     <= Mem_RMask;
            r_aw_pend   <= 1'b1;
            r_w_pend    <= 1'b1;
            r_mem_rdata <= '0;
            if (Mem_Write) begin
              r_fault <= w_mis_st;
            end else if (Mem_Read) begin
              r_fault <= w_mis_ld;
            end else begin
              r_fault <= 1'b0;
            end
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            r_fault     <= (rresp != 2'b00);
            r_mem_rdata <= (rresp != 2'b00) ? '0 : w_load_ext;
          end
        end
        WR_REQ: begin
          if (r_aw_pend && awready) r_aw_pend <= 1'b0;
          if (r_w_pend  && wready)  r_w_pend  <= 1'b0;
        end
        WR_RESP: begin
          if (bvalid) begin
            r_fault     <= (bresp != 2'b00);
            r_mem_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all driven from registered state so they stay stable while a
  // valid is pending.
  // ---------------------------------------------------------------------------
  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign alu_result_W = r_addr;
  assign mem_rdata    = r_mem_rdata;
  assign access_fault = r_fault;

  assign araddr       = {r_addr[31:2], 2'b00};
  assign arvalid      = (r_state == RD_ADDR);
  assign rready       = (r_state == RD_DATA);

  assign awaddr       = {r_addr[31:2], 2'b00};
  assign awvalid      = (r_state == WR_REQ) && r_aw_pend;
  assign wvalid       = (r_state == WR_REQ) && r_w_pend;
  assign wdata        = w_wdata_sh;
  assign wstrb        = r_wmask << r_addr[1:0];
  assign bready       = (r_state == WR_RESP);

endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
module tb_ysyx_24100006_lsu;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] rs2_data;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [7:0]  Mem_WMask;
  logic [2:0]  Mem_RMask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result_W;
  logic [31:0] mem_rdata;
  logic        access_fault;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int errors = 0;
  int checks = 0;

  ysyx_24100006_lsu dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2_data(rs2_data),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_WMask(Mem_WMask), .Mem_RMask(Mem_RMask),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_W(alu_result_W), .mem_rdata(mem_rdata), .access_fault(access_fault),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_bus_inputs();
    arready   = 1'b0;
    rvalid    = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    out_ready = 1'b0;
    rdata     = $urandom;
    rresp     = 2'($urandom_range(3));
    bresp     = 2'($urandom_range(3));
  endtask

  // mode 0: random bus latencies; 1: every ready/valid answered at once;
  // 2: awready at once, wready held off until two cycles later.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd,
                         input logic rd, input logic wr,
                         input logic [7:0] wm, input logic [2:0] rm,
                         input logic [31:0] rdv, input logic [1:0] resp,
                         input int mode, input int hold, output int lat);
    int unsigned off;
    int unsigned size;
    bit          mis;
    bit          nobus;
    bit          done;
    int          cyc;
    logic [31:0] v;
    logic [31:0] e_rd;
    logic [31:0] e_wd;
    logic [7:0]  st8;
    logic [3:0]  e_st;
    logic        e_f;

    // Reference: what the spec says the access must produce.
    off  = addr % 4;
    size = 0;
    if (wr)      size = (wm[3:0] == 4'hF) ? 4 : ((wm[3:0] == 4'h3) ? 2 : 1);
    else if (rd) size = (rm[1:0] == 2'b10) ? 4 : ((rm[1:0] == 2'b01) ? 2 : 1);
    mis   = (size != 0) && ((addr % size) != 0);
    nobus = (size == 0) || mis;
    e_wd  = wd << (8 * off);
    st8   = {4'h0, wm[3:0]} << off;
    e_st  = st8[3:0];
    case (rm)
      3'b000: begin v = (rdv >> (8 * off)) & 32'hFF;
                    if (v >= 128) v = v | 32'hFFFFFF00; end
      3'b100:       v = (rdv >> (8 * off)) & 32'hFF;
      3'b001: begin v = (rdv >> (16 * (off / 2))) & 32'hFFFF;
                    if (v >= 32768) v = v | 32'hFFFF0000; end
      3'b101:       v = (rdv >> (16 * (off / 2))) & 32'hFFFF;
      default:      v = rdv;
    endcase
    e_f  = mis ? 1'b1 : ((size == 0) ? 1'b0 : (resp != 2'b00));
    e_rd = (wr || nobus || resp != 2'b00) ? 32'h0 : v;

    in_valid   = 1'b1;
    alu_result = addr;
    rs2_data   = wd;
    Mem_Read   = rd;
    Mem_Write  = wr;
    Mem_WMask  = wm;
    Mem_RMask  = rm;
    clear_bus_inputs();
    check_eq("in_ready_at_req", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    // Scramble request inputs: the DUT must work from its captured copy.
    in_valid   = 1'b0;
    alu_result = $urandom;
    rs2_data   = $urandom;
    Mem_Read   = 1'($urandom_range(1));
    Mem_Write  = 1'($urandom_range(1));
    Mem_WMask  = 8'($urandom);
    Mem_RMask  = 3'($urandom);

    cyc  = 1;
    done = 0;
    lat  = -1;
    while (!done && cyc < 80) begin
      clear_bus_inputs();
      if (nobus)
        check_eq("no_bus", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'h0);
      if (arvalid) begin
        check_eq("araddr", araddr, addr & 32'hFFFFFFFC);
        arready = (mode != 0) ? 1'b1 : 1'($urandom_range(1));
      end
      if (rready) begin
        rvalid = (mode != 0) ? 1'b1 : 1'($urandom_range(1));
        rdata  = rdv;
        rresp  = resp;
      end
      if (mode == 2 && cyc == 2)
        check_eq("aw_drops_first", 32'({awvalid, wvalid}), 32'h1);
      if (awvalid) begin
        check_eq("awaddr", awaddr, addr & 32'hFFFFFFFC);
        awready = (mode != 0) ? 1'b1 : 1'($urandom_range(1));
      end
      if (wvalid) begin
        check_eq("wdata", wdata, e_wd);
        check_eq("wstrb", 32'(wstrb), 32'(e_st));
        if (mode == 1)      wready = 1'b1;
        else if (mode == 2) wready = (cyc >= 3);
        else                wready = 1'($urandom_range(1));
      end
      if (bready) begin
        bvalid = (mode != 0) ? 1'b1 : 1'($urandom_range(1));
        bresp  = resp;
      end
      if (out_valid) begin
        lat = cyc;
        check_eq("alu_result_W", alu_result_W, addr);
        check_eq("mem_rdata", mem_rdata, e_rd);
        check_eq("access_fault", 32'(access_fault), 32'(e_f));
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          check_eq("hold_valid_noready", 32'({out_valid, in_ready}), 32'h2);
          check_eq("hold_rdata", mem_rdata, e_rd);
          check_eq("hold_fault", 32'(access_fault), 32'(e_f));
          check_eq("hold_addr", alu_result_W, addr);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("after_out_hs", 32'({out_valid, in_ready}), 32'h1);
        done = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!done) begin
      check_eq("timeout", 32'h0, 32'h1);
      reset = 1'b0; #2; reset = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  int          lat;
  logic [31:0] a;
  logic [2:0]  rms [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  logic [3:0]  wms [3] = '{4'h1, 4'h3, 4'hF};

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    alu_result = '0;
    rs2_data   = '0;
    Mem_Read   = 1'b0;
    Mem_Write  = 1'b0;
    Mem_WMask  = '0;
    Mem_RMask  = '0;
    clear_bus_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctrl", 32'({in_ready, out_valid, access_fault, arvalid, rready,
                              awvalid, wvalid, bready}), 32'h80);
    check_eq("rst_araddr", araddr, 32'h0);
    check_eq("rst_awaddr", awaddr, 32'h0);
    check_eq("rst_wdata", wdata, 32'h0);
    check_eq("rst_wstrb", 32'(wstrb), 32'h0);
    check_eq("rst_rdata", mem_rdata, 32'h0);
    check_eq("rst_addrW", alu_result_W, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Non-memory op: result one cycle after accept.
    run_txn(32'h80000010, 32'h0, 1'b0, 1'b0, 8'h0F, 3'b010, 32'h0, 2'b00, 1, 0, lat);
    check_eq("nonmem_latency", 32'(lat), 32'd1);
    // lb / lbu at byte 3 with single-cycle bus answers.
    run_txn(32'h80000003, 32'h0, 1'b1, 1'b0, 8'h00, 3'b000, 32'h80FF1234, 2'b00, 1, 0, lat);
    check_eq("lb_latency", 32'(lat), 32'd3);
    check_eq("lb_value", mem_rdata, 32'hFFFFFF80);
    run_txn(32'h80000003, 32'h0, 1'b1, 1'b0, 8'h00, 3'b100, 32'h80FF1234, 2'b00, 1, 0, lat);
    check_eq("lbu_value", mem_rdata, 32'h00000080);
    // sh with write data accepted two cycles after the address.
    run_txn(32'h80000002, 32'h0000BEEF, 1'b0, 1'b1, 8'h03, 3'b000, 32'h0, 2'b00, 2, 0, lat);
    // Misaligned word load and error response on an aligned word load.
    run_txn(32'h80000001, 32'h0, 1'b1, 1'b0, 8'h00, 3'b010, 32'h12345678, 2'b00, 1, 0, lat);
    check_eq("mis_lw_latency", 32'(lat), 32'd1);
    run_txn(32'h80000004, 32'h0, 1'b1, 1'b0, 8'h00, 3'b010, 32'h12345678, 2'b10, 1, 0, lat);
    // Result held while WBU stalls.
    run_txn(32'h80000020, 32'h0, 1'b1, 1'b0, 8'h00, 3'b001, 32'hA5A5C3C3, 2'b00, 1, 4, lat);

    // Reset pulsed while waiting for read data.
    in_valid   = 1'b1;
    alu_result = 32'h80000100;
    Mem_Read   = 1'b1;
    Mem_Write  = 1'b0;
    Mem_RMask  = 3'b010;
    @(posedge clk); #1;
    in_valid = 1'b0;
    arready  = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    check_eq("rst_mid_rready_before", 32'(rready), 32'h1);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_mid_state", 32'({in_ready, rready, out_valid}), 32'h4);
    #2 reset = 1'b1;
    rvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq("rst_mid_no_out", 32'({out_valid, rready}), 32'h0);
    end
    rvalid = 1'b0;

    // Randomized traffic against the reference.
    for (int n = 0; n < 250; n++) begin
      a = 32'h80000000 | ($urandom & 32'h0000FFFF);
      case ($urandom_range(2))
        0: run_txn(a, $urandom, 1'($urandom_range(1)), 1'b1,
                   {4'($urandom), wms[$urandom_range(2)]}, 3'($urandom),
                   32'h0, 2'($urandom_range(3) == 0 ? 1 + $urandom_range(2) : 0),
                   0, $urandom_range(3), lat);
        1: run_txn(a, $urandom, 1'b1, 1'b0, 8'($urandom), rms[$urandom_range(4)],
                   $urandom, 2'($urandom_range(3) == 0 ? 1 + $urandom_range(2) : 0),
                   0, $urandom_range(3), lat);
        default: run_txn(a, $urandom, 1'b0, 1'b0, 8'($urandom), 3'($urandom),
                         $urandom, 2'b00, 0, $urandom_range(2), lat);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
